// File: rtl/usr_serial_rx_if.sv
// Serial receiver port bundle: line-side strobe/data/order inputs and the
// parallel word with its valid/ack handshake and status flags.
interface usr_serial_rx_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             sdi;
  logic             msb_first;
  logic             ack;
  logic [WIDTH-1:0] y;
  logic             valid;
  logic             busy;
  logic             par_err;
  logic             frm_err;
  logic             ovr;

  modport master (
    output en, sdi, msb_first, ack,
    input  y, valid, busy, par_err, frm_err, ovr
  );

  modport slave (
    input  en, sdi, msb_first, ack,
    output y, valid, busy, par_err, frm_err, ovr
  );
endinterface

// File: rtl/usr_serial_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits in either order,
// optional even parity, stop bit, then a valid/ack handshake on the received word.
module usr_serial_rx #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input logic              clk,
  input logic              rst_n,
  usr_serial_rx_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] y_r;
  logic [CW-1:0]    cnt_r;
  logic             msb_r;
  logic             par_acc_r;
  logic             par_bad_r;
  logic             valid_r;
  logic             busy_r;
  logic             par_err_r;
  logic             frm_err_r;
  logic             ovr_r;

  // Even parity: data bits plus the parity bit must XOR to zero.
  function automatic logic parity_bad_f(input logic acc, input logic par_bit);
    return acc ^ par_bit;
  endfunction

  // Frame FSM with all outputs held in registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      sr_r      <= '0;
      y_r       <= '0;
      cnt_r     <= '0;
      msb_r     <= 1'b0;
      par_acc_r <= 1'b0;
      par_bad_r <= 1'b0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      if (bus.ack) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      if (bus.en) begin
        case (state_r)
          IDLE: begin
            if (!bus.sdi) begin
              state_r   <= DATA;
              busy_r    <= 1'b1;
              msb_r     <= bus.msb_first;
              cnt_r     <= '0;
              par_acc_r <= 1'b0;
              par_bad_r <= 1'b0;
            end else begin
              state_r <= IDLE;
            end
          end
          DATA: begin
            if (msb_r) begin
              sr_r <= {sr_r[WIDTH-2:0], bus.sdi};
            end else begin
              sr_r <= {bus.sdi, sr_r[WIDTH-1:1]};
            end
            par_acc_r <= par_acc_r ^ bus.sdi;
            cnt_r     <= cnt_r + CW'(1);
            if (cnt_r == LAST_BIT) begin
              state_r <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              state_r <= DATA;
            end
          end
          PARITY: begin
            par_bad_r <= parity_bad_f(par_acc_r, bus.sdi);
            state_r   <= STOP;
          end
          STOP: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            if (!bus.sdi) begin
              frm_err_r <= 1'b1;
            end else if (par_bad_r) begin
              par_err_r <= 1'b1;
            end else begin
              // Completion overrides a same-edge ack; only an unacked word overruns.
              y_r     <= sr_r;
              valid_r <= 1'b1;
              if (valid_r && !bus.ack) begin
                ovr_r <= 1'b1;
              end else begin
                ovr_r <= ovr_r;
              end
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.y       = y_r;
  assign bus.valid   = valid_r;
  assign bus.busy    = busy_r;
  assign bus.par_err = par_err_r;
  assign bus.frm_err = frm_err_r;
  assign bus.ovr     = ovr_r;

endmodule

// File: tb/tb_usr_serial_rx.sv
// Directed table-driven bench for usr_serial_rx (WIDTH=4, PARITY_EN=1).
module tb_usr_serial_rx;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic busy_at_start;

  usr_serial_rx_if #(.WIDTH(4)) bus ();

  usr_serial_rx #(.WIDTH(4), .PARITY_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pre_ack;
    logic       msb;
    logic [3:0] d;
    logic       p;
    logic       s;
    logic       ack_s;
    int         period;
    logic [3:0] ey;
    logic       ev;
    logic       epe;
    logic       efe;
    logic       eovr;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic s, input logic e, input logic a, input logic m);
    @(negedge clk);
    bus.sdi       = s;
    bus.en        = e;
    bus.ack       = a;
    bus.msb_first = m;
    @(posedge clk);
    #1;
  endtask

  // Sends start, data (d[3] first), parity, stop; glitches sdi and msb_first between strobes.
  task automatic send_frame(input logic msb, input logic [3:0] d, input logic p,
                            input logic s, input logic ack_s, input int period);
    logic [6:0] f;
    f = {1'b0, d, p, s};
    for (int i = 6; i >= 0; i--) begin
      strobe(f[i], 1'b1, (i == 0) ? ack_s : 1'b0, msb);
      if (i == 6) busy_at_start = bus.busy;
      if (i != 0) begin
        for (int k = 1; k < period; k++) begin
          strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0, ~msb);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.en = 1'b0; bus.sdi = 1'b1; bus.ack = 1'b0; bus.msb_first = 1'b1;
    rst_n = 1'b0;

    //          pre  msb  data     p     s     ack  per ey       ev    epe   efe   eovr
    vecs[0] = '{1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 1, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 3, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 4'b1100, 1'b0, 1'b1, 1'b0, 1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_y", 32'(bus.y), 32'h0);
    chk("reset_valid", 32'(bus.valid), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_flags", 32'({bus.par_err, bus.frm_err, bus.ovr}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].pre_ack) strobe(1'b1, 1'b0, 1'b1, 1'b1);
      send_frame(vecs[v].msb, vecs[v].d, vecs[v].p, vecs[v].s, vecs[v].ack_s, vecs[v].period);
      chk($sformatf("v%0d_y", v), 32'(bus.y), 32'(vecs[v].ey));
      chk($sformatf("v%0d_valid", v), 32'(bus.valid), 32'(vecs[v].ev));
      chk($sformatf("v%0d_par_err", v), 32'(bus.par_err), 32'(vecs[v].epe));
      chk($sformatf("v%0d_frm_err", v), 32'(bus.frm_err), 32'(vecs[v].efe));
      chk($sformatf("v%0d_ovr", v), 32'(bus.ovr), 32'(vecs[v].eovr));
      chk($sformatf("v%0d_busy_start", v), 32'(busy_at_start), 32'h1);
      chk($sformatf("v%0d_busy_stop", v), 32'(bus.busy), 32'h0);
    end

    // Error pulses last exactly one cycle
    strobe(1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 1);
    chk("pe_pulse_hi", 32'(bus.par_err), 32'h1);
    strobe(1'b1, 1'b0, 1'b0, 1'b1);
    chk("pe_pulse_lo", 32'(bus.par_err), 32'h0);
    send_frame(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1);
    chk("fe_pulse_hi", 32'(bus.frm_err), 32'h1);
    chk("fe_no_pe", 32'(bus.par_err), 32'h0);
    strobe(1'b1, 1'b0, 1'b0, 1'b1);
    chk("fe_pulse_lo", 32'(bus.frm_err), 32'h0);

    // sdi=0 without en is not a start bit
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("no_start_en0", 32'(bus.busy), 32'h0);
    strobe(1'b1, 1'b1, 1'b0, 1'b1);
    chk("idle_sdi1", 32'(bus.busy), 32'h0);

    // Reset mid-frame after 3 data bits
    strobe(1'b0, 1'b1, 1'b0, 1'b1);
    strobe(1'b1, 1'b1, 1'b0, 1'b1);
    strobe(1'b0, 1'b1, 1'b0, 1'b1);
    strobe(1'b1, 1'b1, 1'b0, 1'b1);
    chk("mid_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    bus.en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y", 32'(bus.y), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_ovr", 32'(bus.ovr), 32'h0);
    chk("mid_rst_valid", 32'(bus.valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 1);
    chk("post_rst_y", 32'(bus.y), 32'h5);
    chk("post_rst_valid", 32'(bus.valid), 32'h1);
    chk("post_rst_ovr", 32'(bus.ovr), 32'h0);
    strobe(1'b1, 1'b0, 1'b1, 1'b1);
    chk("ack_clears_valid", 32'(bus.valid), 32'h0);
    chk("ack_keeps_y", 32'(bus.y), 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
